// File: rtl/sopc_v3_pio_pkg.sv
// Shared constants for the SOPC v3 input PIO: register word addresses and
// the edge-type encodings used by the EDGE_TYPE parameter.
package sopc_v3_pio_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_RSVD = 2'd1,
      ADDR_MASK = 2'd2,
      ADDR_EDGE = 2'd3
   } pio_addr_e;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/sopc_v3_pio_sync_edge.sv
// Input synchroniser, one-cycle history register and post-reset arm counter.
// Produces the synchronised levels and a qualified per-bit edge vector.
module sopc_v3_pio_sync_edge
   import sopc_v3_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] sync_q,
   output logic [DATA_WIDTH-1:0] edge_vec
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] chain_q, chain_d;
   logic [DATA_WIDTH-1:0]                  prev_q, prev_d;
   logic [ARM_W-1:0]                       arm_cnt_q, arm_cnt_d;
   logic                                   armed;
   logic [DATA_WIDTH-1:0]                  raw_edge;

   assign sync_q = chain_q[SYNC_STAGES-1];
   assign armed  = (arm_cnt_q == ARM_DONE);

   always_comb begin
      chain_d   = {chain_q[SYNC_STAGES-2:0], in_port};
      prev_d    = sync_q;
      arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
   end

   // The arm window covers the cycle in which a level held through reset
   // first reaches sync_q while prev_q is still 0, so it never looks like an edge.
   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: raw_edge = ~sync_q & prev_q;
         EDGE_ANY:     raw_edge = sync_q ^ prev_q;
         default:      raw_edge = sync_q & ~prev_q;
      endcase
      edge_vec = armed ? raw_edge : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain_q   <= '0;
         prev_q    <= '0;
         arm_cnt_q <= '0;
      end else begin
         chain_q   <= chain_d;
         prev_q    <= prev_d;
         arm_cnt_q <= arm_cnt_d;
      end
   end

endmodule

// File: rtl/sopc_v3_pio_in_edge.sv
// Avalon-MM input PIO slave: synchronised level read, sticky write-1-to-clear
// edge capture and a maskable, registered level interrupt.
module sopc_v3_pio_in_edge
   import sopc_v3_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    SYNC_STAGES = 2,
   parameter int                    EDGE_TYPE   = EDGE_RISING,
   parameter logic [DATA_WIDTH-1:0] RESET_MASK  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] sync_q;
   logic [DATA_WIDTH-1:0] edge_vec;
   logic [DATA_WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [31:0]           readdata_q, readdata_d;
   logic                  irq_q, irq_d;
   logic                  wr_en;

   sopc_v3_pio_sync_edge #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_port  (in_port),
      .sync_q   (sync_q),
      .edge_vec (edge_vec)
   );

   assign wr_en = chipselect & ~write_n;

   // Clear is applied first and the new edges OR'd in afterwards, so a
   // coincident edge always survives its own clear.
   always_comb begin
      edge_capture_d = edge_capture_q;
      irq_mask_d     = irq_mask_q;
      if (wr_en && pio_addr_e'(address) == ADDR_EDGE)
         edge_capture_d = edge_capture_q & ~writedata[DATA_WIDTH-1:0];
      if (wr_en && pio_addr_e'(address) == ADDR_MASK)
         irq_mask_d = writedata[DATA_WIDTH-1:0];
      edge_capture_d = edge_capture_d | edge_vec;
   end

   always_comb begin
      readdata_d = '0;
      case (pio_addr_e'(address))
         ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = sync_q;
         ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = irq_mask_q;
         ADDR_EDGE: readdata_d[DATA_WIDTH-1:0] = edge_capture_q;
         default:   readdata_d = '0;
      endcase
      irq_d = |(edge_capture_q & irq_mask_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture_q <= '0;
         irq_mask_q     <= RESET_MASK;
         readdata_q     <= '0;
         irq_q          <= 1'b0;
      end else begin
         edge_capture_q <= edge_capture_d;
         irq_mask_q     <= irq_mask_d;
         readdata_q     <= readdata_d;
         irq_q          <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_sopc_v3_pio_in_edge.sv
// Directed bench for the input PIO: a default 32-bit rising-edge instance and
// an 8-bit any-edge instance with a non-zero reset mask.
module tb_sopc_v3_pio_in_edge;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [1:0]  a_addr;
   logic        a_cs;
   logic        a_wr_n;
   logic [31:0] a_wdata;
   logic [31:0] a_in;
   logic [31:0] a_rd;
   logic        a_irq;

   logic [1:0]  b_addr;
   logic        b_cs;
   logic        b_wr_n;
   logic [31:0] b_wdata;
   logic [7:0]  b_in;
   logic [31:0] b_rd;
   logic        b_irq;

   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   sopc_v3_pio_in_edge dut_a (
      .clk        (clk),
      .reset_n    (rst_n),
      .address    (a_addr),
      .chipselect (a_cs),
      .write_n    (a_wr_n),
      .writedata  (a_wdata),
      .in_port    (a_in),
      .readdata   (a_rd),
      .irq        (a_irq)
   );

   sopc_v3_pio_in_edge #(
      .DATA_WIDTH (8),
      .EDGE_TYPE  (2),
      .RESET_MASK (8'h0F)
   ) dut_b (
      .clk        (clk),
      .reset_n    (rst_n),
      .address    (b_addr),
      .chipselect (b_cs),
      .write_n    (b_wr_n),
      .writedata  (b_wdata),
      .in_port    (b_in),
      .readdata   (b_rd),
      .irq        (b_irq)
   );

   // driver tasks: every step ends 1 time unit after a rising edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [1:0] addr, input logic [31:0] data);
      a_addr = addr; a_cs = 1'b1; a_wr_n = 1'b0; a_wdata = data;
      tick(1);
      a_cs = 1'b0; a_wr_n = 1'b1; a_wdata = '0;
   endtask

   task automatic wr_b(input logic [1:0] addr, input logic [31:0] data);
      b_addr = addr; b_cs = 1'b1; b_wr_n = 1'b0; b_wdata = data;
      tick(1);
      b_cs = 1'b0; b_wr_n = 1'b1; b_wdata = '0;
   endtask

   // scoreboard check
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      a_addr = 2'd0; a_cs = 1'b0; a_wr_n = 1'b1; a_wdata = '0; a_in = 32'hFFFF_FFFF;
      b_addr = 2'd0; b_cs = 1'b0; b_wr_n = 1'b1; b_wdata = '0; b_in = 8'h00;
      tick(3);
      chk("rst_rd_a", a_rd, 32'h0);
      chk("rst_irq_a", {31'h0, a_irq}, 32'h0);

      // release with inputs held high: level visible after 3 edges, no capture
      rst_n = 1'b1;
      tick(2);
      chk("sync_lat2", a_rd, 32'h0);
      tick(1);
      chk("sync_lat3", a_rd, 32'hFFFF_FFFF);
      a_addr = 2'd3;
      tick(4);
      chk("held_no_cap", a_rd, 32'h0);
      chk("held_no_irq", {31'h0, a_irq}, 32'h0);

      // falling edges are ignored in rising mode
      a_in = 32'h0;
      tick(5);
      chk("fall_ignored", a_rd, 32'h0);

      // rising edge on bit 0 with mask 0x1
      wr_a(2'd2, 32'h1);
      a_addr = 2'd3;
      a_in   = 32'h1;
      tick(3);
      chk("cap_edge3_rd", a_rd, 32'h0);
      chk("cap_edge3_irq", {31'h0, a_irq}, 32'h0);
      tick(1);
      chk("cap_edge4_rd", a_rd, 32'h1);
      chk("cap_edge4_irq", {31'h0, a_irq}, 32'h1);
      wr_a(2'd3, 32'h1);
      chk("clr_irq_n", {31'h0, a_irq}, 32'h1);
      tick(1);
      chk("clr_irq_n1", {31'h0, a_irq}, 32'h0);
      chk("clr_rd", a_rd, 32'h0);

      // clear of bit 5 lands on the same edge that sets it
      a_in = 32'h21;
      tick(2);
      wr_a(2'd3, 32'h20);
      tick(1);
      chk("set_beats_clr", a_rd, 32'h20);
      wr_a(2'd3, 32'h20);
      tick(1);
      chk("plain_clr", a_rd, 32'h0);

      // mask 0: capture without irq, then open the mask
      wr_a(2'd2, 32'h0);
      a_addr = 2'd3;
      a_in   = 32'h27;
      tick(5);
      chk("mask0_cap", a_rd, 32'h6);
      chk("mask0_irq", {31'h0, a_irq}, 32'h0);
      wr_a(2'd2, 32'hFF);
      chk("mask_irq_n", {31'h0, a_irq}, 32'h0);
      tick(1);
      chk("mask_irq_n1", {31'h0, a_irq}, 32'h1);
      chk("mask_rd", a_rd, 32'hFF);

      // 8-bit any-edge instance
      b_addr = 2'd2;
      tick(1);
      chk("b_reset_mask", b_rd, 32'h0F);
      b_addr = 2'd3;
      b_in   = 8'h80;
      tick(4);
      chk("b_tog1", b_rd, 32'h80);
      b_in = 8'h00;
      tick(4);
      chk("b_tog2", b_rd, 32'h80);
      exp_q.push_back(32'h00);
      exp_q.push_back(32'h00);
      exp_q.push_back(32'h0F);
      exp_q.push_back(32'h80);
      for (int a = 0; a < 4; a++) begin
         b_addr = 2'(a);
         tick(1);
         chk($sformatf("b_addr%0d", a), b_rd, exp_q.pop_front());
      end
      wr_b(2'd3, 32'h80);
      tick(1);
      chk("b_clr", b_rd, 32'h0);
      chk("b_irq_masked", {31'h0, b_irq}, 32'h0);
      b_in   = 8'hFF;
      b_addr = 2'd0;
      tick(4);
      chk("b_level", b_rd, 32'hFF);
      wr_b(2'd2, 32'hFFFF_FFFF);
      tick(1);
      chk("b_mask_trunc", b_rd, 32'hFF);
      chk("b_irq", {31'h0, b_irq}, 32'h1);

      // build capture 0xA5 with irq high on instance a, then reset mid-run
      wr_a(2'd3, 32'hFFFF_FFFF);
      a_addr = 2'd3;
      a_in   = 32'h0;
      tick(4);
      a_in = 32'hA5;
      tick(5);
      chk("pre_rst_cap", a_rd, 32'hA5);
      chk("pre_rst_irq", {31'h0, a_irq}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_rd", a_rd, 32'h0);
      chk("async_irq", {31'h0, a_irq}, 32'h0);
      chk("async_irq_b", {31'h0, b_irq}, 32'h0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      chk("post_rst_cap", a_rd, 32'h0);
      a_addr = 2'd2;
      b_addr = 2'd2;
      tick(1);
      chk("post_rst_mask_a", a_rd, 32'h0);
      chk("post_rst_mask_b", b_rd, 32'h0F);
      a_addr = 2'd3;
      b_addr = 2'd3;
      tick(5);
      chk("rearm_no_cap_a", a_rd, 32'h0);
      chk("rearm_no_cap_b", b_rd, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
